// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - transmit request/status bundle for uart_tx
//
// Purpose: carries the per-frame configuration, the write request and the
//          serial/status outputs between a requester (master) and uart_tx (slave).
// Signals:
//   clock_divider_i  clock cycles per serial bit (0 behaves as 1)
//   parity_bit_i     1 appends a parity bit after the data bits
//   parity_even_i    1 even parity, 0 odd parity
//   data_i           byte to transmit
//   write_i          request to transmit data_i
//   serial_o         serial line, idles high
//   busy_o           high while a frame is in progress
//   done_o           one-cycle pulse when a frame completes
interface uart_tx_if #(
  parameter int CLOCK_DIVIDER_WIDTH = 8
);
  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i;
  logic                           parity_bit_i;
  logic                           parity_even_i;
  logic [7:0]                     data_i;
  logic                           write_i;
  logic                           serial_o;
  logic                           busy_o;
  logic                           done_o;

  modport master (
    output clock_divider_i, parity_bit_i, parity_even_i, data_i, write_i,
    input  serial_o, busy_o, done_o
  );

  modport slave (
    input  clock_divider_i, parity_bit_i, parity_even_i, data_i, write_i,
    output serial_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with optional parity and per-frame bit time
//
// Purpose: serialises one byte per accepted write as start, 8 data bits
//          (LSB first), optional parity and stop, each held for D clocks.
// Ports:
//   clock_i   single clock, rising edge
//   reset_i   synchronous, active-low reset
//   bus       uart_tx_if slave: configuration, write request, serial/busy/done
module uart_tx #(
  parameter int CLOCK_DIVIDER_WIDTH = 8
) (
  input  logic      clock_i,
  input  logic      reset_i,
  uart_tx_if.slave  bus
);

  localparam int W = CLOCK_DIVIDER_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state, w_state_next;
  logic [W-1:0] r_cnt, w_cnt_next;
  logic [W-1:0] r_div, w_div_next;
  logic [2:0]  r_idx, w_idx_next;
  logic [7:0]  r_data, w_data_next;
  logic        r_par_en, w_par_en_next;
  logic        r_par_even, w_par_even_next;
  logic        r_serial, w_serial_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;

  logic [W-1:0] w_bit_len;
  logic         w_bit_end;
  logic [2:0]   w_idx_inc;
  logic         w_parity_val;

  // A latched divider of zero is stretched to one clock per bit.
  assign w_bit_len    = (r_div == '0) ? W'(1) : r_div;
  // Counter runs 0..D-1; D-1 always fits in W bits, so no overflow at max D.
  assign w_bit_end    = (r_cnt == (w_bit_len - W'(1)));
  // Natural 3-bit wrap takes the index from 7 back to 0 on leaving DATA.
  assign w_idx_inc    = r_idx + 3'd1;
  assign w_parity_val = r_par_even ? (^r_data) : ~(^r_data);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_div_next      = r_div;
    w_idx_next      = r_idx;
    w_data_next     = r_data;
    w_par_en_next   = r_par_en;
    w_par_even_next = r_par_even;
    w_serial_next   = r_serial;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
        if (bus.write_i && !r_busy) begin
          w_data_next     = bus.data_i;
          w_div_next      = bus.clock_divider_i;
          w_par_en_next   = bus.parity_bit_i;
          w_par_even_next = bus.parity_even_i;
          w_state_next    = S_START;
          w_cnt_next      = '0;
          w_idx_next      = 3'd0;
          w_serial_next   = 1'b0;
          w_busy_next     = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_cnt_next    = '0;
          w_idx_next    = 3'd0;
          w_state_next  = S_DATA;
          w_serial_next = r_data[0];
        end else begin
          w_cnt_next = r_cnt + W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          w_idx_next = w_idx_inc;
          if (r_idx == 3'd7) begin
            if (r_par_en) begin
              w_state_next  = S_PARITY;
              w_serial_next = w_parity_val;
            end else begin
              w_state_next  = S_STOP;
              w_serial_next = 1'b1;
            end
          end else begin
            w_serial_next = r_data[w_idx_inc];
          end
        end else begin
          w_cnt_next = r_cnt + W'(1);
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_next    = '0;
          w_state_next  = S_STOP;
          w_serial_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_next    = '0;
          w_state_next  = S_IDLE;
          w_serial_next = 1'b1;
          w_busy_next   = 1'b0;
          w_done_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + W'(1);
        end
      end

      default: begin
        w_state_next  = S_IDLE;
        w_cnt_next    = '0;
        w_idx_next    = 3'd0;
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_idx      <= 3'd0;
      r_data     <= 8'h00;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_div      <= w_div_next;
      r_idx      <= w_idx_next;
      r_data     <= w_data_next;
      r_par_en   <= w_par_en_next;
      r_par_even <= w_par_even_next;
      r_serial   <= w_serial_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.serial_o = r_serial;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.CLOCK_DIVIDER_WIDTH(8)) bus ();

  uart_tx #(.CLOCK_DIVIDER_WIDTH(8)) dut (
    .clock_i (clk),
    .reset_i (rstn),
    .bus     (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
  endtask

  // Line level for bit slot idx of a frame: start, 8 data LSB first, parity?, stop.
  function automatic logic bit_at(input logic [7:0] d, input bit par, input bit even, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && par) return even ? (^d) : ~(^d);
    return 1'b1;
  endfunction

  task automatic start_write(input logic [7:0] d, input int div, input bit par, input bit even);
    bus.data_i          = d;
    bus.clock_divider_i = div[7:0];
    bus.parity_bit_i    = par;
    bus.parity_even_i   = even;
    bus.write_i         = 1'b1;
  endtask

  // Called at a negedge with a write already presented; checks every cycle of
  // the frame. inj_at: cycle to present an extra write with altered inputs.
  // abort_at: cycle after which reset is pulsed. chain: present the next
  // write at the earliest legal point (done cycle, or reset release).
  task automatic run_frame(input logic [7:0] d, input int div, input bit par, input bit even,
                           input int inj_at, input int abort_at, input bit chain,
                           input logic [7:0] nd, input int ndiv, input bit npar, input bit neven);
    int bt;
    int n;
    logic es, eb, ed;
    bt = (div == 0) ? 1 : div;
    n  = par ? 11 : 10;
    @(posedge clk);
    for (int k = 0; k <= n * bt + 1; k++) begin
      @(negedge clk);
      if (abort_at >= 0 && k == abort_at + 1) begin
        chk("abort_serial", k, bus.serial_o, 1'b1);
        chk("abort_busy",   k, bus.busy_o,   1'b0);
        chk("abort_done",   k, bus.done_o,   1'b0);
        rstn = 1'b1;
        if (chain) start_write(nd, ndiv, npar, neven);
        else bus.write_i = 1'b0;
        return;
      end
      if (k < n * bt) begin
        es = bit_at(d, par, even, k / bt); eb = 1'b1; ed = 1'b0;
      end else if (k == n * bt) begin
        es = 1'b1; eb = 1'b0; ed = 1'b1;
      end else begin
        es = 1'b1; eb = 1'b0; ed = 1'b0;
      end
      chk("serial", k, bus.serial_o, es);
      chk("busy",   k, bus.busy_o,   eb);
      chk("done",   k, bus.done_o,   ed);
      if (k == 0) bus.write_i = 1'b0;
      if (k == inj_at) begin
        bus.write_i         = 1'b1;
        bus.data_i          = 8'h00;
        bus.clock_divider_i = 8'd3;
        bus.parity_bit_i    = ~par;
        bus.parity_even_i   = ~even;
      end
      if (inj_at >= 0 && k == inj_at + 1) bus.write_i = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
        rstn        = 1'b0;
        bus.write_i = 1'b1;
      end
      if (chain && k == n * bt) begin
        start_write(nd, ndiv, npar, neven);
        return;
      end
    end
  endtask

  logic [7:0] rd [0:8];
  int         rdiv [0:8];
  bit         rpar [0:8];
  bit         reven [0:8];
  bit         rch [0:8];

  initial begin
    rstn                = 1'b0;
    bus.write_i         = 1'b1;
    bus.data_i          = 8'hFF;
    bus.clock_divider_i = 8'd8;
    bus.parity_bit_i    = 1'b0;
    bus.parity_even_i   = 1'b0;

    // Reset state, with a write held during reset that must be ignored.
    repeat (3) @(negedge clk);
    chk("rst_serial", 0, bus.serial_o, 1'b1);
    chk("rst_busy",   0, bus.busy_o,   1'b0);
    chk("rst_done",   0, bus.done_o,   1'b0);

    // First write accepted on the first edge after reset release.
    rstn = 1'b1;
    start_write(8'h55, 8, 1'b0, 1'b0);
    run_frame(8'h55, 8, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    @(negedge clk); start_write(8'h07, 8, 1'b1, 1'b1);
    run_frame(8'h07, 8, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk); start_write(8'h07, 8, 1'b1, 1'b0);
    run_frame(8'h07, 8, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Write mid-frame with altered config must not disturb the frame.
    @(negedge clk); start_write(8'hAA, 8, 1'b0, 1'b0);
    run_frame(8'hAA, 8, 1'b0, 1'b0, 20, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Back-to-back at D=1.
    @(negedge clk); start_write(8'hAA, 1, 1'b0, 1'b0);
    run_frame(8'hAA, 1, 1'b0, 1'b0, -1, -1, 1'b1, 8'h55, 1, 1'b0, 1'b0);
    run_frame(8'h55, 1, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Reset at cycle 30, then a parity frame right after release.
    @(negedge clk); start_write(8'h3C, 8, 1'b0, 1'b0);
    run_frame(8'h3C, 8, 1'b0, 1'b0, -1, 30, 1'b1, 8'hC3, 8, 1'b1, 1'b1);
    run_frame(8'hC3, 8, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Divider 0 behaves as 1; maximum divider 255.
    @(negedge clk); start_write(8'h55, 0, 1'b0, 1'b0);
    run_frame(8'h55, 0, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk); start_write(8'h96, 255, 1'b1, 1'b0);
    run_frame(8'h96, 255, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    // Randomized frames, some chained back-to-back.
    for (int i = 0; i < 9; i++) begin
      rd[i]    = 8'($urandom);
      rdiv[i]  = int'($urandom_range(0, 6));
      rpar[i]  = 1'($urandom);
      reven[i] = 1'($urandom);
      rch[i]   = 1'($urandom);
    end
    @(negedge clk); start_write(rd[0], rdiv[0], rpar[0], reven[0]);
    for (int i = 0; i < 8; i++) begin
      run_frame(rd[i], rdiv[i], rpar[i], reven[i], -1, -1, rch[i],
                rd[i+1], rdiv[i+1], rpar[i+1], reven[i+1]);
      if (!rch[i]) begin
        @(negedge clk); start_write(rd[i+1], rdiv[i+1], rpar[i+1], reven[i+1]);
      end
    end
    run_frame(rd[8], rdiv[8], rpar[8], reven[8], -1, -1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
